// File: rtl/fib_bin2bcd.sv
// Sequential shift-and-add-3 binary to packed BCD converter, one bit per clock.
// Define FIB_BCD_SAT_EN to saturate bcd to all nines on overflow.
module fib_bin2bcd #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);
    localparam int NS3 = (BIN_W + 2) / 3;
    localparam int NS  = (DIGITS > NS3) ? DIGITS : NS3;
    localparam int CW  = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [BIN_W-1:0]    sr;
    logic [BIN_W-1:0]    sr_nx;
    logic [4*NS-1:0]     dig;
    logic [4*NS-1:0]     adj;
    logic [4*NS-1:0]     dig_nx;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] bcd_nx;
    logic                ovf_nx;
    logic                load;
    logic                last;

    assign last = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Correct every digit in parallel, then shift digits and operand as one vector
    always_comb begin
        adj = '0;
        for (int i = 0; i < NS; i++) begin
            if (dig[4*i +: 4] >= 4'd5) adj[4*i +: 4] = dig[4*i +: 4] + 4'd3;
            else                       adj[4*i +: 4] = dig[4*i +: 4];
        end
        dig_nx = {adj[4*NS-2:0], sr[BIN_W-1]};
        sr_nx  = {sr[BIN_W-2:0], 1'b0};
        ovf_nx = |(dig_nx >> (4 * DIGITS));
`ifdef FIB_BCD_SAT_EN
        bcd_nx = ovf_nx ? {DIGITS{4'h9}} : dig_nx[4*DIGITS-1:0];
`else
        bcd_nx = dig_nx[4*DIGITS-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            dig <= '0;
            cnt <= '0;
            bcd <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            sr  <= bin;
            dig <= '0;
            cnt <= '0;
        end else if (state == SHIFT) begin
            sr  <= sr_nx;
            dig <= dig_nx;
            cnt <= cnt + CW'(1);
            if (last) begin
                bcd <= bcd_nx;
                ovf <= ovf_nx;
            end
        end
    end

endmodule

// File: tb/tb_fib_bin2bcd.sv
// Self-checking bench for fib_bin2bcd: decimal reference model plus directed vectors.
// Honours FIB_BCD_SAT_EN the same way as the design.
module tb_fib_bin2bcd;
    localparam int BIN_W = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    int n_pass = 0;
    int n_total = 0;

    fib_bin2bcd #(.BIN_W(BIN_W), .DIGITS(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bin(bin),
        .busy(busy),
        .done(done),
        .bcd(bcd),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        int r;
        logic [15:0] o;
`ifdef FIB_BCD_SAT_EN
        if (v > 9999) return 16'h9999;
`endif
        r = v % 10000;
        o = '0;
        for (int k = 0; k < 4; k++) begin
            o[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return o;
    endfunction

    // Transaction-level model: an accepted value emerges BIN_W+1 cycles later
    int          pend = 0;
    int          pval = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_bcd = '0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            pend = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_bcd = '0;
            m_ovf = 1'b0;
            chk_en = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                pend--;
                if (pend == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_bcd = ref_bcd(pval);
                    m_ovf = (pval > 9999);
                end
            end else if (start) begin
                pend = BIN_W;
                m_busy = 1'b1;
                pval = int'(bin);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("bcd", 32'(bcd), 32'(m_bcd));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("busy_done_excl", 32'(busy & done), 32'd0);
        end
    end

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) bc++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic run(input logic [13:0] v, output int lat, output int bc);
        @(posedge clk);
        #1 start = 1'b1;
        bin = v;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
    endtask

    initial begin
        int lat;
        int bc;
        int a;
        int b;
        int t;
        logic [15:0] sat_10946;
        logic [15:0] sat_16383;
`ifdef FIB_BCD_SAT_EN
        sat_10946 = 16'h9999;
        sat_16383 = 16'h9999;
`else
        sat_10946 = 16'h0946;
        sat_16383 = 16'h6383;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_ovf", 32'(ovf), 32'd0);

        check("ref_4181", 32'(ref_bcd(4181)), 32'h4181);
        check("ref_9999", 32'(ref_bcd(9999)), 32'h9999);
        check("ref_10946", 32'(ref_bcd(10946)), 32'(sat_10946));

        run(14'd0, lat, bc);
        check("lat_0", lat, 15);
        check("busy_cycles_0", bc, 14);
        check("bcd_0", 32'(bcd), 32'h0);
        check("ovf_0", 32'(ovf), 32'd0);

        run(14'd4181, lat, bc);
        check("bcd_4181", 32'(bcd), 32'h4181);
        check("ovf_4181", 32'(ovf), 32'd0);
        run(14'd9999, lat, bc);
        check("bcd_9999", 32'(bcd), 32'h9999);
        check("ovf_9999", 32'(ovf), 32'd0);
        run(14'd10946, lat, bc);
        check("bcd_10946", 32'(bcd), 32'(sat_10946));
        check("ovf_10946", 32'(ovf), 32'd1);
        run(14'd16383, lat, bc);
        check("bcd_16383", 32'(bcd), 32'(sat_16383));
        check("ovf_16383", 32'(ovf), 32'd1);

        // start during SHIFT is ignored; start in DONE is accepted
        @(posedge clk);
        #1 start = 1'b1;
        bin = 14'd89;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        bin = 14'd144;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        check("lat_89", lat, 10);
        check("bcd_89", 32'(bcd), 32'h0089);
        start = 1'b1;
        bin = 14'd233;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        check("lat_233", lat, 15);
        check("bcd_233", 32'(bcd), 32'h0233);

        // reset mid-conversion, with a coincident start
        @(posedge clk);
        #1 start = 1'b1;
        bin = 14'd1597;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        start = 1'b1;
        bin = 14'd5;
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd), 32'h0);
        bc = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) bc++;
        end
        check("abort_no_done", bc, 0);
        run(14'd610, lat, bc);
        check("lat_610", lat, 15);
        check("bcd_610", 32'(bcd), 32'h0610);

        // back-to-back Fibonacci sweep
        a = 0;
        b = 1;
        @(posedge clk);
        #1 start = 1'b1;
        bin = 14'(a);
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            wait_done(lat, bc);
            check($sformatf("fib%0d_lat", i), lat, 15);
            check($sformatf("fib%0d_bcd", i), 32'(bcd), 32'(ref_bcd(a)));
            check($sformatf("fib%0d_ovf", i), 32'(ovf), 32'd0);
            t = a + b;
            a = b;
            b = t;
            if (i < 20) begin
                start = 1'b1;
                bin = 14'(a);
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        check("fib20_literal", 32'(bcd), 32'h6765);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fib_bin2bcd.md
# fib_bin2bcd

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) between the Fibonacci term generator and the 4-digit seven-segment multiplexer. It accepts one binary term per `start` pulse and delivers packed BCD digits plus an overflow flag with a one-cycle `done` strobe. The display mux latches `bcd` on `done`.

## Interface
- `BIN_W`, 14, width of binary input; legal range 4..20
- `DIGITS`, 4, number of BCD digits presented on `bcd`
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request conversion of `bin`; sampled only when `busy`=0
- `bin`  in  BIN_W  unsigned binary value, sampled on accepted `start`
- `busy`  out  1  conversion in progress
- `done`  out  1  one-cycle pulse: `bcd`/`ovf` updated this cycle
- `bcd`  out  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]
- `ovf`  out  1  last converted value exceeded 10^DIGITS−1

## Operation
- Internal scratch: `bin` shift register plus NS = max(DIGITS, ceil(BIN_W/3)) BCD digits; bit counter of ceil(log2(BIN_W+1)) bits.
- States: IDLE, SHIFT, DONE.
- IDLE: `busy`=0. On `start`=1: load shift register with `bin`, clear all NS digits, counter←0, go SHIFT.
- SHIFT: `busy`=1. Each cycle: every scratch digit ≥5 gets +3 (all digits in parallel, 4-bit add, no carry between digits), then the digits+shift register shift left by one as a single vector; MSB of the shift register enters digit 0 bit 0. Counter increments; after the BIN_W-th shift go DONE.
- DONE: `busy`=0, `done`=1. `bcd` ← low DIGITS scratch digits (or saturated, see Configuration); `ovf` ← OR of all scratch digits at index ≥ DIGITS being nonzero. If `start`=1 in this cycle, it is accepted (load as in IDLE, next state SHIFT); else IDLE.
- `start` while `busy`=1: ignored, no queuing; `bin` changes during SHIFT have no effect.
- `bcd`/`ovf` hold their value between `done` pulses.
- Every scratch digit stays ≤9 at all times; no digit value 10..15 ever appears on `bcd`.

## Timing
- Reset values: `busy`=0, `done`=0, `bcd`=0, `ovf`=0, state IDLE, scratch cleared.
- `start` accepted at edge N → `busy`=1 for cycles N+1..N+BIN_W → `done`=1, `busy`=0, new `bcd`/`ovf` visible in cycle N+BIN_W+1.
- Latency BIN_W+1 cycles (15 for default); back-to-back throughput one result per BIN_W+1 cycles.
- `done` never asserted two consecutive cycles; `busy` and `done` never both 1.
- `rst` during SHIFT or DONE: abort, no `done` pulse, outputs to reset values next cycle; a `start` coincident with `rst` is dropped.

## Configuration
- `FIB_BCD_SAT_EN` defined: when overflow is detected, `bcd` is forced to all nines (0x9999 for DIGITS=4) and `ovf`=1.
- Not defined: `bcd` carries the low DIGITS decimal digits (value mod 10^DIGITS), `ovf`=1.
- `ovf` behaviour and all timing are identical in both builds.

## Test plan
- Reset, then `start` with `bin`=0 → `done` 15 cycles after accept, `bcd`=0x0000, `ovf`=0; `busy` high exactly 14 cycles.
- `bin`=4181 (Fib 19) → `bcd`=0x4181, `ovf`=0; `bin`=9999 → `bcd`=0x9999, `ovf`=0.
- `bin`=10946 (Fib 21) → `ovf`=1; `bcd`=0x0946 without `FIB_BCD_SAT_EN`, 0x9999 with it; `bin`=16383 → `bcd`=0x6383 / 0x9999, `ovf`=1.
- Accept `bin`=89, pulse `start` with `bin`=144 at cycle 5 of SHIFT → ignored, single `done` with `bcd`=0x0089; then `start` held high in DONE cycle with `bin`=233 → accepted, next `done` exactly 15 cycles later with `bcd`=0x0233.
- Accept `bin`=1597, assert `rst` at SHIFT cycle 7 → no `done`, `bcd`=0, `busy`=0 next cycle; new `start` `bin`=610 → `bcd`=0x0610 after 15 cycles.
- Sweep Fib(0)..Fib(20) back-to-back, compare each `bcd` against a decimal reference model and check `done` spacing of 15 cycles.
